// File: rtl/sopc_nios_processor_oci_dct_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sopc_nios_processor_oci_dct_packer_pkg
// Purpose  : Shared widths, slot count and state encoding for the trace
//            item packer.
// Contents : DCT_ITEM_W, DCT_SLOTS, DCT_BUF_W, DCT_CNT_W, state_t
// Revision : 1.0 - initial release
// ============================================================================
package sopc_nios_processor_oci_dct_packer_pkg;

  localparam int DCT_ITEM_W = 2;
  localparam int DCT_SLOTS  = 15;
  localparam int DCT_BUF_W  = 30;
  localparam int DCT_CNT_W  = 4;

  // Accumulator occupancy at which a buffer is complete.
  localparam logic [DCT_CNT_W-1:0] CNT_FULL = DCT_CNT_W'(DCT_SLOTS);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } state_t;

endpackage : sopc_nios_processor_oci_dct_packer_pkg
`default_nettype wire

// File: rtl/sopc_nios_processor_oci_dct_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : sopc_nios_processor_oci_dct_packer_if
// Purpose  : Groups the item input stream and the packed-buffer output
//            stream of the packer.
// Modports : master - environment side (offers items, consumes buffers)
//            slave  - packer side
// Revision : 1.0 - initial release
// ============================================================================
interface sopc_nios_processor_oci_dct_packer_if;
  import sopc_nios_processor_oci_dct_packer_pkg::*;

  logic                  in_valid;
  logic [DCT_ITEM_W-1:0] in_data;
  logic                  in_ready;
  logic                  dct_valid;
  logic                  dct_ready;
  logic [DCT_BUF_W-1:0]  dct_buffer;
  logic [DCT_CNT_W-1:0]  dct_count;

  modport master (
    output in_valid, in_data, dct_ready,
    input  in_ready, dct_valid, dct_buffer, dct_count
  );

  modport slave (
    input  in_valid, in_data, dct_ready,
    output in_ready, dct_valid, dct_buffer, dct_count
  );

endinterface : sopc_nios_processor_oci_dct_packer_if
`default_nettype wire

// File: rtl/sopc_nios_processor_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : sopc_nios_processor_oci_dct_packer
// Purpose  : Packs 2-bit trace items LSB-first into a 15-slot accumulator,
//            hands full (or, at end of capture, partial) buffers to a single
//            output register, and sequences the end-of-capture flush.
// Ports    : clk            - clock, rising edge
//            reset_n        - asynchronous active-low reset
//            bus            - item stream in / buffer stream out (slave)
//            flush          - single-cycle end-of-capture request
//            test_ending    - final buffer issued, awaiting consumption
//            test_has_ended - capture complete, sticky until reset
// Revision : 1.0 - initial release
// ============================================================================
module sopc_nios_processor_oci_dct_packer
  import sopc_nios_processor_oci_dct_packer_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset_n,
  sopc_nios_processor_oci_dct_packer_if.slave  bus,
  input  logic                                 flush,
  output logic                                 test_ending,
  output logic                                 test_has_ended
);

  state_t                 state;
  state_t                 state_next;

  logic [DCT_BUF_W-1:0]   acc;
  logic [DCT_CNT_W-1:0]   acc_cnt;
  logic                   out_valid;
  logic [DCT_BUF_W-1:0]   out_buf;
  logic [DCT_CNT_W-1:0]   out_cnt;

  logic                   slot_free;
  logic                   handshake;
  logic                   in_ready_c;
  logic                   load_full;
  logic                   load_part;
  logic                   load;
  logic                   accept;
  logic                   ending_c;
  logic                   ended_c;
  logic [4:0]             slot_lsb;

  // The output register can take a new buffer when it is empty or is being
  // consumed on this very cycle, which permits back-to-back moves.
  assign handshake = out_valid && bus.dct_ready;
  assign slot_free = !out_valid || bus.dct_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    load_full  = 1'b0;
    load_part  = 1'b0;
    ending_c   = 1'b0;
    ended_c    = 1'b0;
    case (state)
      ST_RUN: begin
        // A full accumulator blocks input for the cycle it waits to move.
        in_ready_c = (acc_cnt != CNT_FULL);
        load_full  = (acc_cnt == CNT_FULL) && slot_free;
        if (flush) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          // An empty accumulator is never issued as a buffer.
          load_part  = (acc_cnt != '0);
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ending_c = 1'b1;
        if (slot_free) begin
          state_next = ST_ENDED;
        end
      end
      ST_ENDED: begin
        ended_c = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign load     = load_full || load_part;
  assign accept   = bus.in_valid && in_ready_c;
  assign slot_lsb = {acc_cnt, 1'b0};

  // Loads and accepts never coincide: in_ready is low whenever a load can
  // fire (full accumulator in RUN, or any cycle outside RUN).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      out_buf   <= '0;
      out_cnt   <= '0;
    end else begin
      if (load) begin
        out_buf   <= acc;
        out_cnt   <= acc_cnt;
        out_valid <= 1'b1;
        acc       <= '0;
        acc_cnt   <= '0;
      end else begin
        if (handshake) begin
          out_valid <= 1'b0;
        end
        if (accept) begin
          acc[slot_lsb +: DCT_ITEM_W] <= bus.in_data;
          acc_cnt                     <= acc_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.dct_valid   = out_valid;
  assign bus.dct_buffer  = out_buf;
  assign bus.dct_count   = out_cnt;
  assign test_ending     = ending_c;
  assign test_has_ended  = ended_c;

endmodule : sopc_nios_processor_oci_dct_packer
`default_nettype wire

// File: tb/tb_sopc_nios_processor_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sopc_nios_processor_oci_dct_packer
// Purpose  : Self-checking bench for the trace item packer: a table of
//            single-capture vectors plus hand-written multi-cycle sequences
//            (continuous streaming, back-pressure, idle flush, flush with a
//            same-cycle item, reset during drain).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sopc_nios_processor_oci_dct_packer;

  logic clk;
  logic reset_n;
  logic flush;
  logic test_ending;
  logic test_has_ended;

  int n_checks;
  int n_fail;

  sopc_nios_processor_oci_dct_packer_if bus ();

  sopc_nios_processor_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .flush          (flush),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [29:0] data;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
    logic        exp_ending;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 2'b00;
    bus.dct_ready = 1'b0;
    flush         = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Offers n items (item k = data[2k+1:2k]); optionally raises flush on the
  // cycle the last item is accepted.
  task automatic send_items(input int n, input logic [29:0] data, input bit flush_last);
    for (int k = 0; k < n; k++) begin
      int guard;
      bus.in_valid = 1'b1;
      bus.in_data  = data[2*k +: 2];
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: item %0d never accepted (in_ready %b, wanted 1)", k, bus.in_ready);
      end
      flush = flush_last && (k == n - 1);
      tick();
      flush = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Items are packed LSB-first; these values are the hand-packed buffers.
    // 15 items 0,1,2,3,0,... : three 0xE4 bytes, then items 0,1,2 -> 6'b100100.
    vecs[0] = '{1,  30'h2,        30'h2,        4'd1,  1'b1};
    vecs[1] = '{5,  30'h3FF,      30'h3FF,      4'd5,  1'b1};
    vecs[2] = '{3,  30'h39,       30'h39,       4'd3,  1'b1};
    vecs[3] = '{8,  30'h6666,     30'h6666,     4'd8,  1'b1};
    vecs[4] = '{14, 30'h5555555,  30'h5555555,  4'd14, 1'b1};
    vecs[5] = '{15, 30'h24E4E4E4, 30'h24E4E4E4, 4'd15, 1'b0};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_valid",     {31'd0, bus.dct_valid}, 32'd0);
    check("rst_buffer",    {2'd0, bus.dct_buffer}, 32'd0);
    check("rst_count",     {28'd0, bus.dct_count}, 32'd0);
    check("rst_ending",    {31'd0, test_ending},   32'd0);
    check("rst_ended",     {31'd0, test_has_ended}, 32'd0);

    // ---------------- table vectors ----------------
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send_items(vecs[v].n, vecs[v].data, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      // Consumer stalls: the buffer must sit there untouched.
      for (int c = 0; c < 3; c++) tick();
      check($sformatf("v%0d_valid", v),  {31'd0, bus.dct_valid},  32'd1);
      check($sformatf("v%0d_buffer", v), {2'd0, bus.dct_buffer},  {2'd0, vecs[v].exp_buf});
      check($sformatf("v%0d_count", v),  {28'd0, bus.dct_count},  {28'd0, vecs[v].exp_cnt});
      check($sformatf("v%0d_ending", v), {31'd0, test_ending},    {31'd0, vecs[v].exp_ending});
      bus.dct_ready = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      check($sformatf("v%0d_ended", v),   {31'd0, test_has_ended}, 32'd1);
      check($sformatf("v%0d_valid_end", v), {31'd0, bus.dct_valid}, 32'd0);
    end

    // flush in ENDED is ignored and the state stays sticky
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("ended_sticky", {31'd0, test_has_ended}, 32'd1);
    check("ended_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // ---------------- continuous stream, consumer always ready ----------------
    begin
      int sent, lows, nbuf;
      logic [29:0] cap_buf;
      logic [3:0]  cap_cnt;
      do_reset();
      bus.dct_ready = 1'b1;
      sent = 0; lows = 0; nbuf = 0; cap_buf = '0; cap_cnt = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        bus.in_valid = (sent < 15);
        bus.in_data  = 2'(sent % 4);
        if (bus.dct_valid) begin
          nbuf++;
          cap_buf = bus.dct_buffer;
          cap_cnt = bus.dct_count;
        end
        if (!bus.in_ready) lows++;
        if (bus.in_valid && bus.in_ready) sent++;
        tick();
      end
      bus.in_valid = 1'b0;
      check("stream_sent",   sent, 32'd15);
      check("stream_nbuf",   nbuf, 32'd1);
      check("stream_buffer", {2'd0, cap_buf}, 32'h24E4E4E4);
      check("stream_count",  {28'd0, cap_cnt}, 32'd15);
      check("stream_bubble", lows, 32'd1);
    end

    // ---------------- back-pressure with two full buffers ----------------
    begin
      int unstable;
      do_reset();
      send_items(15, 30'h15555555, 1'b0);
      send_items(15, 30'h2AAAAAAA, 1'b0);
      unstable = 0;
      for (int c = 0; c < 20; c++) begin
        if (bus.dct_buffer !== 30'h15555555 || bus.dct_count !== 4'd15 ||
            bus.dct_valid !== 1'b1 || bus.in_ready !== 1'b0) unstable++;
        tick();
      end
      check("bp_stable",  unstable, 32'd0);
      check("bp_first",   {2'd0, bus.dct_buffer}, 32'h15555555);
      bus.dct_ready = 1'b1;
      tick();
      check("bp_second_valid", {31'd0, bus.dct_valid}, 32'd1);
      check("bp_second",  {2'd0, bus.dct_buffer}, 32'h2AAAAAAA);
      check("bp_second_count", {28'd0, bus.dct_count}, 32'd15);
      check("bp_second_inready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check("bp_drained", {31'd0, bus.dct_valid}, 32'd0);
    end

    // ---------------- flush with empty accumulator ----------------
    begin
      int waited;
      bit saw_valid;
      do_reset();
      bus.dct_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      waited = 0;
      saw_valid = 1'b0;
      while (!test_has_ended && waited < 6) begin
        if (bus.dct_valid) saw_valid = 1'b1;
        tick();
        waited++;
      end
      check("idle_flush_no_valid", {31'd0, saw_valid}, 32'd0);
      check("idle_flush_ended",    {31'd0, test_has_ended}, 32'd1);
      check("idle_flush_latency",  (waited <= 2) ? 32'd1 : 32'd0, 32'd1);
    end

    // ---------------- item accepted on the flush cycle ----------------
    do_reset();
    send_items(3, 30'h39, 1'b1);
    tick();
    check("flushitem_count",  {28'd0, bus.dct_count},  32'd3);
    check("flushitem_buffer", {2'd0, bus.dct_buffer},  32'h39);
    check("flushitem_ending", {31'd0, test_ending},    32'd1);

    // ---------------- reset during DRAIN ----------------
    do_reset();
    send_items(2, 30'hF, 1'b1);
    tick();
    tick();
    check("drain_pre_ending", {31'd0, test_ending}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("drain_rst_valid",  {31'd0, bus.dct_valid},  32'd0);
    check("drain_rst_buffer", {2'd0, bus.dct_buffer},  32'd0);
    check("drain_rst_count",  {28'd0, bus.dct_count},  32'd0);
    check("drain_rst_ending", {31'd0, test_ending},    32'd0);
    check("drain_rst_ended",  {31'd0, test_has_ended}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send_items(1, 30'h2, 1'b1);
    tick();
    check("post_rst_count",  {28'd0, bus.dct_count}, 32'd1);
    check("post_rst_buffer", {2'd0, bus.dct_buffer}, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sopc_nios_processor_oci_dct_packer
`default_nettype wire
